// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding
// and the default operand width.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam int SUB_WIDTH_DEF = 8;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Combinational 1-bit full subtractor cell: diff = a - b - bin, with the
// borrow out raised when the subtraction needs to borrow from the next bit.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    // Single-bit difference and borrow generation
    always_comb begin
        diff = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, LSB first, one bit per clock.
// Build option: define SERIAL_SUB_SAT_EN to publish diff as 0 whenever the
// final borrow is set (unsigned saturation); borrow_out is unaffected.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_sh_reg, b_sh_reg, res_reg;
    logic [WIDTH-1:0] res_shift, res_pub;
    logic [WIDTH-1:0] diff_reg;
    logic [CW-1:0]    cnt_reg;
    logic             borrow_reg, borrow_out_reg;
    logic             cell_d, cell_bout;
    logic             accept, last_bit;

    // The design's only arithmetic: one cell fed by the operand LSBs
    full_subtractor u_cell (
        .a    (a_sh_reg[0]),
        .b    (b_sh_reg[0]),
        .bin  (borrow_reg),
        .diff (cell_d),
        .bout (cell_bout)
    );

    // Result register shifted right with the new difference bit entering at the MSB
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_res
        if (gi == WIDTH - 1) begin : g_msb
            assign res_shift[gi] = cell_d;
        end else begin : g_lo
            assign res_shift[gi] = res_reg[gi+1];
        end
    end

`ifdef SERIAL_SUB_SAT_EN
    assign res_pub = cell_bout ? '0 : res_shift;
`else
    assign res_pub = res_shift;
`endif

    assign last_bit = (cnt_reg == CW'(WIDTH - 1));
    assign accept   = ready & start;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_next = state_reg;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            S_IDLE: begin
                ready = 1'b1;
                if (start) state_next = S_SHIFT;
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (last_bit) state_next = S_DONE;
            end
            S_DONE: begin
                ready      = 1'b1;
                done       = 1'b1;
                state_next = start ? S_SHIFT : S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Serial datapath: load on accept, shift one bit per SHIFT cycle, publish on the last bit
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_reg       <= '0;
            b_sh_reg       <= '0;
            res_reg        <= '0;
            borrow_reg     <= 1'b0;
            cnt_reg        <= '0;
            diff_reg       <= '0;
            borrow_out_reg <= 1'b0;
        end else if (accept) begin
            a_sh_reg   <= a;
            b_sh_reg   <= b;
            borrow_reg <= 1'b0;
            cnt_reg    <= '0;
        end else if (state_reg == S_SHIFT) begin
            a_sh_reg   <= a_sh_reg >> 1;
            b_sh_reg   <= b_sh_reg >> 1;
            res_reg    <= res_shift;
            borrow_reg <= cell_bout;
            cnt_reg    <= cnt_reg + CW'(1);
            if (last_bit) begin
                diff_reg       <= res_pub;
                borrow_out_reg <= cell_bout;
            end
        end
    end

    assign diff       = diff_reg;
    assign borrow_out = borrow_out_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8) with hand-computed results.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a, b;
    logic       ready, busy, done, borrow_out;
    logic [7:0] diff;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] last_diff;
    logic       last_bor;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Wait (bounded) for done; cyc starts at 1 for the cycle after the accepting edge
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // One complete transaction with start pulsed for a single cycle
    task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                          input logic [7:0] ed, input logic eb);
        int cyc;
        a = ta; b = tb_v; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy"}, busy, 1);
        check({tag, "_ready_low"}, ready, 0);
        check({tag, "_hold"}, {borrow_out, diff}, {last_bor, last_diff});
        wait_done(cyc);
        check({tag, "_latency"}, cyc, 9);
        check({tag, "_diff"}, diff, ed);
        check({tag, "_borrow"}, borrow_out, eb);
        $display("op %s a=%02h b=%02h diff=%02h borrow=%0d cycles=%0d", tag, ta, tb_v, diff, borrow_out, cyc);
        last_diff = ed; last_bor = eb;
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_idle"}, ready, 1);
    endtask

    initial begin
        int cyc;
        logic [7:0] sat_f0, sat_ff;
        logic       saw_done;
`ifdef SERIAL_SUB_SAT_EN
        sat_f0 = 8'h00; sat_ff = 8'h00;
`else
        sat_f0 = 8'hF0; sat_ff = 8'hFF;
`endif
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        last_diff = '0; last_bor = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_borrow", borrow_out, 0);

        run_op("basic", 8'h5A, 8'h21, 8'h39, 1'b0);
        run_op("under", 8'h10, 8'h20, sat_f0, 1'b1);
        run_op("equal", 8'hFF, 8'hFF, 8'h00, 1'b0);
        run_op("zero_max", 8'h00, 8'hFF, 8'h01, 1'b1);

        // Back-to-back with start held high
        a = 8'h80; b = 8'h01; start = 1'b1;
        @(negedge clk);
        wait_done(cyc);
        check("b2b1_latency", cyc, 9);
        check("b2b1_diff", diff, 8'h7F);
        check("b2b1_borrow", borrow_out, 0);
        $display("op b2b1 a=80 b=01 diff=%02h borrow=%0d cycles=%0d", diff, borrow_out, cyc);
        a = 8'h01; b = 8'h02;
        @(negedge clk);
        check("b2b2_busy", busy, 1);
        check("b2b2_done_low", done, 0);
        wait_done(cyc);
        check("b2b2_latency", cyc, 9);
        check("b2b2_diff", diff, sat_ff);
        check("b2b2_borrow", borrow_out, 1);
        $display("op b2b2 a=01 b=02 diff=%02h borrow=%0d cycles=%0d", diff, borrow_out, cyc);
        start = 1'b0;
        @(negedge clk);
        check("b2b_idle", ready, 1);

        // Start during SHIFT is ignored
        a = 8'hC8; b = 8'h64; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a = 8'hAA; b = 8'h55; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 4;
        while (done !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("ign_latency", cyc, 9);
        check("ign_diff", diff, 8'h64);
        check("ign_borrow", borrow_out, 0);
        $display("op ignore a=c8 b=64 diff=%02h borrow=%0d cycles=%0d", diff, borrow_out, cyc);
        @(negedge clk);

        // Reset in the middle of SHIFT
        a = 8'h77; b = 8'h11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", ready, 1);
        check("abort_busy", busy, 0);
        check("abort_diff", diff, 0);
        check("abort_borrow", borrow_out, 0);
        saw_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done === 1'b1) saw_done = 1'b1;
            @(negedge clk);
        end
        check("abort_no_done", saw_done, 0);
        $display("op abort a=77 b=11 diff=%02h borrow=%0d", diff, borrow_out);
        last_diff = '0; last_bor = 1'b0;
        run_op("post_rst", 8'h03, 8'h01, 8'h02, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial unsigned N-bit subtractor computing a - b, LSB first, one bit per clock, with a start/done handshake. It is the inverse-operation counterpart of the team's combinational adder cells. It targets area-constrained datapaths that accept multi-cycle latency in exchange for a single 1-bit subtractor cell.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 1 to 64.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst  input  1  synchronous reset, active-high.
start  input  1  request pulse; sampled only when ready=1.
a  input  WIDTH  minuend; captured on the accepting edge.
b  input  WIDTH  subtrahend; captured on the accepting edge.
ready  output  1  high in IDLE and DONE states.
busy  output  1  high in SHIFT state.
done  output  1  one-cycle pulse when the result is valid.
diff  output  WIDTH  result a - b modulo 2^WIDTH; saturated value if the optional feature is enabled.
borrow_out  output  1  final borrow; 1 means a < b.

Behaviour:
- Interface: one clock clk; synchronous active-high reset rst.
- Reset (rst=1 at an edge):
  - State goes to IDLE; ready=1; busy=0; done=0; diff=0; borrow_out=0.
  - Operand shift registers, bit counter and borrow flip-flop are cleared.
  - rst has priority over start.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - ready=1.
  - start=1 at an edge loads a and b into shift registers, clears borrow and count, and moves to SHIFT.
- SHIFT (each edge):
  - Bit cell computes d = a0 ^ b0 ^ bin and bout = (~a0 & b0) | (~(a0 ^ b0) & bin), where bin is the borrow flip-flop.
  - d is shifted into the MSB of the result shift register; operand registers shift right; borrow flip-flop takes bout; count increments.
  - When count reaches WIDTH-1 on that edge, go to DONE.
- DONE (one cycle):
  - done=1; diff and borrow_out update from the result register and borrow flip-flop on the edge entering DONE.
  - Next edge: if start=1, accept new operands and go to SHIFT (back-to-back); otherwise go to IDLE.
- Latency: start accepted at edge E0; done is high in the cycle after edge E0+WIDTH, i.e. WIDTH+1 cycles from acceptance. Throughput is one result per WIDTH+1 cycles.
- diff and borrow_out hold their values until the next result is published; they do not change during SHIFT.
- start while busy=1 is ignored and not queued.
- a and b changing after acceptance have no effect.
- Reset mid-SHIFT aborts the operation; no done pulse is produced and outputs clear to 0.
- WIDTH=1: SHIFT lasts a single cycle.
- Equal operands give diff=0, borrow_out=0.
- a=0 with b=2^WIDTH-1 gives diff=1, borrow_out=1.

Optional Feature:
SERIAL_SUB_SAT_EN
- Defined: when the final borrow is 1, diff is published as 0 (unsigned saturation). borrow_out is still 1.
- Undefined: diff is always the modulo-2^WIDTH result.
- Timing and handshake are identical in both builds.

Decomposition:
- Shared package serial_sub_pkg contains:
  - state encoding constants S_IDLE=2'd0, S_SHIFT=2'd1, S_DONE=2'd2;
  - default width constant SUB_WIDTH_DEF=8.
- One sub-module: full_subtractor, a combinational 1-bit cell with inputs a, b, bin and outputs diff, bout. It is instantiated once; it is the serial datapath's only arithmetic.
- Counter width is $clog2(WIDTH+1), computed locally.

Test Plan:
- WIDTH=8, reset then a=0x5A, b=0x21, start pulse: done exactly 9 cycles after acceptance; diff=0x39; borrow_out=0; ready low during SHIFT.
- a=0x10, b=0x20: diff=0xF0, borrow_out=1; with SERIAL_SUB_SAT_EN defined, diff=0x00, borrow_out=1.
- a=0xFF, b=0xFF, then a=0x00, b=0xFF: results diff=0x00/borrow 0, then diff=0x01/borrow 1.
- Start held high continuously with new operands each DONE cycle: back-to-back results every 9 cycles; busy reasserts the cycle after done.
- start pulsed at SHIFT cycle 3 with different operands: ignored; result matches the original operands.
- rst asserted at SHIFT cycle 4: next cycle ready=1, busy=0, diff=0, borrow_out=0; no done pulse. A following start of a=0x03, b=0x01 gives diff=0x02.
